// File: rtl/uart_rx_frame_assembler.sv
// Pulls bytes from a show-ahead Rx FIFO and assembles SYNC + payload + XOR-checksum
// frames into one word, with back-pressure on the consumer side and an idle timeout.
module uart_rx_frame_assembler #(
    parameter int unsigned           DBITS      = 8,
    parameter int unsigned           WORD_BYTES = 4,
    parameter logic [DBITS-1:0]      SYNC_BYTE  = 8'hA5,
    parameter int unsigned           TIMEOUT    = 100000,
    parameter int unsigned           TO_BITS    = 17
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        rx_empty,
    input  logic [DBITS-1:0]            read_data,
    output logic                        read_uart,
    output logic [WORD_BYTES*DBITS-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        chk_err,
    output logic                        timeout_err,
    output logic [7:0]                  drop_count
);

    localparam int unsigned        IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic logic [DBITS-1:0] xor_fold(input logic [DBITS-1:0] acc,
                                                  input logic [DBITS-1:0] data);
        return acc ^ data;
    endfunction

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DBITS-1:0]              xor_q, xor_d;
    logic [TO_BITS-1:0]            to_q, to_d;
    logic [WORD_BYTES*DBITS-1:0]   word_q, word_d;
    logic [7:0]                    drop_q, drop_d;
    logic                          chk_q, chk_d;
    logic                          tout_q, tout_d;
    logic                          pop_s;
    logic                          to_hit_s;
    logic                          drop_inc_s;

    // Pop strobe: only in states that consume bytes and only when data is present.
    always_comb begin
        pop_s = 1'b0;
        if ((state_q == HUNT) || (state_q == DATA) || (state_q == CHECK)) begin
            pop_s = ~rx_empty;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign to_hit_s = (to_q == TO_LAST);

    // Next-state, datapath and error-pulse logic for the frame FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        to_d       = to_q;
        word_d     = word_q;
        chk_d      = 1'b0;
        tout_d     = 1'b0;
        drop_inc_s = 1'b0;
        case (state_q)
            HUNT: begin
                to_d = '0;
                if (pop_s && (read_data == SYNC_BYTE)) begin
                    idx_d   = '0;
                    xor_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = HUNT;
                end
            end
            DATA: begin
                if (pop_s) begin
                    to_d  = '0;
                    xor_d = xor_fold(xor_q, read_data);
                    for (int k = 0; k < WORD_BYTES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            word_d[k*DBITS +: DBITS] = read_data;
                        end else begin
                            word_d[k*DBITS +: DBITS] = word_q[k*DBITS +: DBITS];
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (to_hit_s) begin
                    to_d       = '0;
                    tout_d     = 1'b1;
                    drop_inc_s = 1'b1;
                    state_d    = HUNT;
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            CHECK: begin
                if (pop_s) begin
                    to_d = '0;
                    if (read_data == xor_q) begin
                        state_d = HOLD;
                    end else begin
                        chk_d      = 1'b1;
                        drop_inc_s = 1'b1;
                        state_d    = HUNT;
                    end
                end else if (to_hit_s) begin
                    to_d       = '0;
                    tout_d     = 1'b1;
                    drop_inc_s = 1'b1;
                    state_d    = HUNT;
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            HOLD: begin
                to_d = '0;
                if (word_ready) begin
                    state_d = HUNT;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HUNT;
                to_d    = '0;
            end
        endcase
    end

    // Bad-frame counter sticks at 255 instead of wrapping.
    always_comb begin
        drop_d = drop_q;
        if (drop_inc_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HUNT;
            idx_q   <= '0;
            xor_q   <= '0;
            to_q    <= '0;
            word_q  <= '0;
            drop_q  <= 8'd0;
            chk_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            to_q    <= to_d;
            word_q  <= word_d;
            drop_q  <= drop_d;
            chk_q   <= chk_d;
            tout_q  <= tout_d;
        end
    end

    // Strobes are forced low while reset is held, even before the first edge.
    assign read_uart   = pop_s & ~RST;
    assign word_valid  = (state_q == HOLD) & ~RST;
    assign chk_err     = chk_q & ~RST;
    assign timeout_err = tout_q & ~RST;
    assign word_out    = word_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench: show-ahead FIFO model feeding the assembler, one task per scenario.
module tb_uart_rx_frame_assembler;

    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  read_data = 8'h00;
    logic        read_uart;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        chk_err;
    logic        timeout_err;
    logic [7:0]  drop_count;

    logic [7:0]  fifo[$];
    logic [31:0] acc_q[$];
    logic        pop_pending = 1'b0;
    int          pops = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_wv = 0;
    int          n_chk = 0;
    int          n_to = 0;
    int          n_viol = 0;

    uart_rx_frame_assembler #(
        .DBITS(8), .WORD_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .TO_BITS(8)
    ) dut (
        .CLK(CLK), .RST(RST), .rx_empty(rx_empty), .read_data(read_data),
        .read_uart(read_uart), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .chk_err(chk_err), .timeout_err(timeout_err),
        .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    // FIFO model: apply the pop taken at the last rising edge, then present the new head.
    always @(negedge CLK) begin
        if (pop_pending && (fifo.size() > 0)) begin
            void'(fifo.pop_front());
            pops++;
        end
        rx_empty  = (fifo.size() == 0);
        read_data = rx_empty ? 8'h00 : fifo[0];
        #3;
        pop_pending = read_uart;
    end

    task automatic tick();
        if (word_valid && word_ready) acc_q.push_back(word_out);
        @(negedge CLK);
        #2;
        if (word_valid) n_wv++;
        if (chk_err) n_chk++;
        if (timeout_err) n_to++;
        if (read_uart && rx_empty) n_viol++;
        if (chk_err && timeout_err) n_viol++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [31:0] w, input logic [7:0] c);
        fifo.push_back(s);
        for (int i = 0; i < 4; i++) fifo.push_back(w[i*8 +: 8]);
        fifo.push_back(c);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ticks(3);
        checks++;
        if ({read_uart, word_valid, chk_err, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=0000", {read_uart, word_valid, chk_err, timeout_err});
        end
        checks++;
        if (drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_drop got=%0d want=0", drop_count);
        end
        checks++;
        if (word_out !== 32'h0) begin
            errors++; $display("FAIL reset_word got=%h want=00000000", word_out);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        int p0, wv0, c0;
        p0 = pops; wv0 = n_wv; c0 = n_chk;
        acc_q.delete();
        word_ready = 1'b1;
        push_frame(8'hA5, 32'h44332211, 8'h44);
        ticks(12);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h44332211) begin
            errors++; $display("FAIL good_word n=%0d got=%h want=44332211", acc_q.size(), word_out);
        end
        checks++;
        if (n_wv - wv0 != 1) begin
            errors++; $display("FAIL good_valid_cycles got=%0d want=1", n_wv - wv0);
        end
        checks++;
        if (pops - p0 != 6) begin
            errors++; $display("FAIL good_pops got=%0d want=6", pops - p0);
        end
        checks++;
        if (drop_count !== 8'd0 || n_chk != c0) begin
            errors++; $display("FAIL good_drop got=%0d want=0", drop_count);
        end
    endtask

    task automatic test_bad_checksum();
        int wv0, c0, p0;
        wv0 = n_wv; c0 = n_chk; p0 = pops;
        push_frame(8'hA5, 32'h04030201, 8'h00);
        ticks(12);
        checks++;
        if (n_chk - c0 != 1) begin
            errors++; $display("FAIL bad_chk_pulses got=%0d want=1", n_chk - c0);
        end
        checks++;
        if (drop_count !== 8'd1) begin
            errors++; $display("FAIL bad_drop got=%0d want=1", drop_count);
        end
        checks++;
        if (n_wv != wv0 || pops - p0 != 6) begin
            errors++; $display("FAIL bad_novalid valid=%0d pops=%0d want 0/6", n_wv - wv0, pops - p0);
        end
    endtask

    task automatic test_hunt_backpressure();
        int held, waited;
        logic [31:0] w;
        word_ready = 1'b0;
        acc_q.delete();
        fifo.push_back(8'h00); fifo.push_back(8'hFF);
        push_frame(8'hA5, 32'hEFBEADDE, 8'h22);
        waited = 0;
        while (!word_valid && waited < 30) begin tick(); waited++; end
        checks++;
        if (!word_valid) begin
            errors++; $display("FAIL hunt_valid_timeout got=0 want=1");
        end
        w = word_out;
        checks++;
        if (w !== 32'hEFBEADDE) begin
            errors++; $display("FAIL hunt_word got=%h want=EFBEADDE", w);
        end
        fifo.push_back(8'h00);
        held = (word_valid && !read_uart) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (word_valid && !read_uart && word_out === w) held++;
        end
        checks++;
        if (held != 20) begin
            errors++; $display("FAIL hold_cycles got=%0d want=20", held);
        end
        word_ready = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0 || read_uart !== 1'b1) begin
            errors++; $display("FAIL accept_resume valid=%b pop=%b want 0/1", word_valid, read_uart);
        end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'hEFBEADDE) begin
            errors++; $display("FAIL accept_word n=%0d want 1 of EFBEADDE", acc_q.size());
        end
        ticks(2);
    endtask

    task automatic test_timeout();
        int t0, c0, cnt;
        logic [7:0] d0;
        t0 = n_to; c0 = n_chk; d0 = drop_count; cnt = 0;
        fifo.push_back(8'hA5); fifo.push_back(8'h01);
        while (n_to == t0 && cnt < 3*TMO) begin tick(); cnt++; end
        ticks(5);
        checks++;
        if (n_to - t0 != 1 || n_chk != c0) begin
            errors++; $display("FAIL timeout_pulses got=%0d want=1", n_to - t0);
        end
        checks++;
        if (cnt < TMO || cnt > TMO + 8) begin
            errors++; $display("FAIL timeout_latency got=%0d want=%0d..%0d", cnt, TMO, TMO + 8);
        end
        checks++;
        if (drop_count !== d0 + 8'd1) begin
            errors++; $display("FAIL timeout_drop got=%0d want=%0d", drop_count, d0 + 8'd1);
        end
        acc_q.delete();
        word_ready = 1'b1;
        push_frame(8'hA5, 32'h40302010, 8'h40);
        ticks(12);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h40302010) begin
            errors++; $display("FAIL after_timeout_word n=%0d got=%h want=40302010", acc_q.size(), word_out);
        end
    endtask

    task automatic test_pop_wins();
        int t0;
        t0 = n_to;
        acc_q.delete();
        word_ready = 1'b1;
        fifo.push_back(8'hA5);
        ticks(TMO);
        fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
        fifo.push_back(8'h04); fifo.push_back(8'h04);
        ticks(12);
        checks++;
        if (n_to != t0) begin
            errors++; $display("FAIL popwins_timeout got=%0d want=0", n_to - t0);
        end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h04030201) begin
            errors++; $display("FAIL popwins_word n=%0d got=%h want=04030201", acc_q.size(), word_out);
        end
    endtask

    task automatic test_saturation_reset();
        int c0, guard;
        c0 = n_chk; guard = 0;
        for (int f = 0; f < 300; f++) push_frame(8'hA5, 32'h04030201, 8'h00);
        while (fifo.size() > 0 && guard < 3000) begin tick(); guard++; end
        ticks(4);
        checks++;
        if (drop_count !== 8'd255) begin
            errors++; $display("FAIL sat_drop got=%0d want=255", drop_count);
        end
        checks++;
        if (n_chk - c0 != 300) begin
            errors++; $display("FAIL sat_chk_pulses got=%0d want=300", n_chk - c0);
        end
        fifo.push_back(8'hA5); fifo.push_back(8'h11);
        fifo.push_back(8'h22); fifo.push_back(8'h33);
        ticks(3);
        RST = 1'b1;
        tick();
        checks++;
        if ({read_uart, word_valid, chk_err, timeout_err} !== 4'b0000 || rx_empty !== 1'b0) begin
            errors++;
            $display("FAIL midreset_strobes got=%b empty=%b want=0000 0", {read_uart, word_valid, chk_err, timeout_err}, rx_empty);
        end
        checks++;
        if (drop_count !== 8'd0 || word_out !== 32'h0) begin
            errors++; $display("FAIL midreset_state drop=%0d word=%h want 0/0", drop_count, word_out);
        end
        RST = 1'b0;
        acc_q.delete();
        word_ready = 1'b1;
        push_frame(8'hA5, 32'h44332211, 8'h44);
        ticks(14);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h44332211 || drop_count !== 8'd0) begin
            errors++; $display("FAIL postreset_frame n=%0d drop=%0d want 1 of 44332211 drop 0", acc_q.size(), drop_count);
        end
    endtask

    task automatic test_sync_payload();
        int wv0;
        wv0 = n_wv;
        acc_q.delete();
        word_ready = 1'b1;
        push_frame(8'hA5, 32'hA5A5A5A5, 8'h00);
        ticks(12);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'hA5A5A5A5 || n_wv - wv0 != 1) begin
            errors++; $display("FAIL sync_payload n=%0d got=%h want=A5A5A5A5", acc_q.size(), word_out);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pops;
        acc_q.delete();
        word_ready = 1'b1;
        push_frame(8'hA5, 32'h08040201, 8'h0F);
        push_frame(8'hA5, 32'h80402010, 8'hF0);
        ticks(20);
        checks++;
        if (acc_q.size() != 2) begin
            errors++; $display("FAIL b2b_count got=%0d want=2", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== 32'h08040201 || acc_q[1] !== 32'h80402010) begin
                errors++; $display("FAIL b2b_words got=%h %h want=08040201 80402010", acc_q[0], acc_q[1]);
            end
        end
        checks++;
        if (pops - p0 != 12) begin
            errors++; $display("FAIL b2b_pops got=%0d want=12", pops - p0);
        end
        checks++;
        if (n_viol != 0) begin
            errors++; $display("FAIL protocol_violations got=%0d want=0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_hunt_backpressure();
        test_timeout();
        test_pop_wins();
        test_sync_payload();
        test_back_to_back();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_assembler.md
UART_RX_FRAME_ASSEMBLER -- requirements
Module: uart_rx_frame_assembler

Interface
Parameters and ports are listed one per line.
REQ-001 SHALL have parameter DBITS, default 8: width of one received byte.
REQ-002 SHALL have parameter WORD_BYTES, default 4: number of payload bytes per frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 SHALL have parameter TIMEOUT, default 100000: maximum idle clock cycles allowed between bytes inside a frame.
REQ-005 SHALL have parameter TO_BITS, default 17: width of the timeout counter.
REQ-006 SHALL have port CLK, input, 1: the only clock; all logic on rising edge.
REQ-007 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port rx_empty, input, 1: Rx FIFO holds no data.
REQ-009 SHALL have port read_data, input, DBITS: Rx FIFO head byte, show-ahead; it advances the cycle after a pop.
REQ-010 SHALL have port read_uart, output, 1: one-cycle pop strobe to the Rx FIFO.
REQ-011 SHALL have port word_out, output, WORD_BYTES*DBITS: assembled payload.
REQ-012 SHALL have port word_valid, output, 1: word_out is valid.
REQ-013 SHALL have port word_ready, input, 1: consumer accepts word_out.
REQ-014 SHALL have port chk_err, output, 1: one-cycle pulse when a checksum mismatch is detected.
REQ-015 SHALL have port timeout_err, output, 1: one-cycle pulse when a frame is abandoned on timeout.
REQ-016 SHALL have port drop_count, output, 8: saturating count of bad frames.

Function
REQ-017 SHALL accept frames of the form SYNC_BYTE, then WORD_BYTES payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-018 SHALL use a state machine with states HUNT, DATA, CHECK and HOLD.
REQ-019 SHALL assert read_uart = ~rx_empty only in HUNT, DATA and CHECK, and SHALL take the consumed byte from read_data in the same cycle; pops on back-to-back cycles are allowed.
REQ-020 SHALL never assert read_uart in HOLD, and SHALL never assert it while rx_empty = 1.
REQ-021 HUNT SHALL discard every byte that is not SYNC_BYTE; on SYNC_BYTE it SHALL clear the byte index and running XOR, then go to DATA.
REQ-022 DATA SHALL place payload byte k (k = 0 first) into word_out[k*DBITS +: DBITS] and SHALL XOR it into the running checksum.
REQ-023 DATA SHALL go to CHECK after byte WORD_BYTES-1.
REQ-024 A SYNC_BYTE value arriving inside DATA SHALL be treated as payload and SHALL NOT restart the frame.
REQ-025 CHECK, on a checksum match, SHALL go to HOLD and assert word_valid on the next cycle.
REQ-026 CHECK, on a mismatch, SHALL pulse chk_err for one cycle, increment drop_count, and go to HUNT; word_valid SHALL stay 0.
REQ-027 HOLD SHALL keep word_valid = 1 and word_out stable until a cycle with word_ready = 1, then go to HUNT with word_valid = 0 on the following cycle.
REQ-028 Pops SHALL resume in the cycle after that acceptance.
REQ-029 word_ready SHALL be ignored whenever word_valid = 0.
REQ-030 The timeout counter SHALL clear on every pop and in HUNT and HOLD, and SHALL increment on every other cycle in DATA and CHECK.
REQ-031 When the timeout counter reaches TIMEOUT-1 without a pop, the block SHALL pulse timeout_err, increment drop_count, and go to HUNT.
REQ-032 If a pop and the timeout condition fall in the same cycle, the pop SHALL win and no timeout SHALL occur.
REQ-033 drop_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-034 chk_err and timeout_err SHALL never be asserted in the same cycle.
REQ-035 word_out SHALL be updated only in DATA and SHALL hold its value in all other states.

Reset
REQ-036 When RST = 1 at a clock edge, the state SHALL become HUNT, with byte index, running XOR, timeout counter and drop_count = 0, regardless of the current state.
REQ-037 While RST = 1, read_uart, word_valid, chk_err and timeout_err SHALL be 0.
REQ-038 word_out SHALL reset to all zeros.
REQ-039 A reset in the middle of a frame SHALL discard that frame and SHALL NOT count it in drop_count.

Verification
REQ-040 SHALL test a good frame: FIFO holds A5 11 22 33 44 44, word_ready = 1 -> word_out = 32'h44332211 with word_valid for 1 cycle, 6 pops, drop_count = 0.
REQ-041 SHALL test a bad checksum: FIFO holds A5 01 02 03 04 00 -> chk_err pulses once, drop_count = 1, no word_valid.
REQ-042 SHALL test hunting and back-pressure: FIFO holds 00 FF A5 DE AD BE EF 22 with word_ready = 0 for 20 cycles -> word_out = 32'hEFBEADDE, word_valid held 20 cycles, read_uart = 0 throughout, then accepted.
REQ-043 SHALL test timeout: FIFO holds A5 01 with no more data for TIMEOUT cycles -> timeout_err pulses once, state returns to HUNT, and a following good frame is received correctly.
REQ-044 SHALL test saturation and reset: 300 bad frames -> drop_count = 255; then RST = 1 in the middle of a frame -> all outputs 0, and the next good frame is received correctly.
REQ-045 SHALL test a payload containing the sync value: FIFO holds A5 A5 A5 A5 A5 00 -> word_out = 32'hA5A5A5A5 with word_valid asserted.
